// File: rtl/rom_load_arbiter.sv
// ROM download / CPU read arbiter for a single-port ROM RAM, plus game reset sequencing.
// Optional ROM_LOAD_CSUM_EN adds a 16-bit running sum of bytes written to RAM.
//
// state | meaning
// BOOT  | no image yet, waiting for a download to start
// LOAD  | download active, host writes flow through the buffer
// DRAIN | download ended, flushing the last buffered write
// HOLD  | settle period, hold counter running down
// RUN   | image valid, game out of reset
module rom_load_arbiter #(
  parameter int AW          = 15,
  parameter int ROM_SIZE    = 16384,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dn_download,
  input  logic          dn_wr,
  input  logic [AW-1:0] dn_addr,
  input  logic [7:0]    dn_data,
  output logic          dn_wait,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  output logic [7:0]    cpu_dout,
  output logic          cpu_valid,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic          mem_we,
  input  logic [7:0]    mem_dout,
  output logic          game_reset,
  output logic          load_done
`ifdef ROM_LOAD_CSUM_EN
  ,
  output logic [15:0]   csum
`endif
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [31:0]   ROM_LIMIT = 32'(ROM_SIZE);

  typedef enum logic [2:0] {BOOT, LOAD, DRAIN, HOLD, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   hold_cnt, hold_cnt_nxt;
  logic            load_done_q = 1'b0;
  logic            load_done_nxt;
  logic            load_entry;

  logic            buf_full;
  logic [AW-1:0]   buf_addr;
  logic [7:0]      buf_data;
  logic            buf_in_range;
  logic            last_grant_wr;
  logic            rd_valid_q;
  logic            grant_wr, grant_rd;

  // Grants are suppressed while reset is high so the RAM port sits idle.
  assign buf_in_range = 32'(buf_addr) < ROM_LIMIT;
  assign grant_wr     = !reset && buf_full && (!cpu_rd || !last_grant_wr);
  assign grant_rd     = !reset && cpu_rd && (!buf_full || last_grant_wr);

  assign mem_we     = grant_wr && buf_in_range;
  assign mem_addr   = grant_wr ? buf_addr : (grant_rd ? cpu_addr : '0);
  assign mem_din    = grant_wr ? buf_data : '0;
  assign dn_wait    = buf_full && !reset;
  assign cpu_valid  = rd_valid_q && !reset;
  assign cpu_dout   = cpu_valid ? mem_dout : '0;
  assign game_reset = reset || (state != RUN);
  assign load_done  = load_done_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      buf_full      <= 1'b0;
      buf_addr      <= '0;
      buf_data      <= '0;
      last_grant_wr <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      if (grant_wr) begin
        buf_full <= 1'b0;
      end else if (dn_wr && !buf_full) begin
        buf_full <= 1'b1;
        buf_addr <= dn_addr;
        buf_data <= dn_data;
      end
      if (grant_wr) begin
        last_grant_wr <= 1'b1;
      end else if (grant_rd) begin
        last_grant_wr <= 1'b0;
      end
      rd_valid_q <= grant_rd;
    end
  end

  // load_done survives reset so a re-reset of a loaded game only replays the hold.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= load_done_q ? HOLD : BOOT;
      hold_cnt <= HOLD_LAST;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      load_done_q <= load_done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_cnt_nxt  = hold_cnt;
    load_done_nxt = load_done_q;
    load_entry    = 1'b0;
    case (state)
      BOOT:  state_nxt = BOOT;
      LOAD:  if (!dn_download) state_nxt = DRAIN;
      DRAIN: begin
        if (!buf_full) begin
          state_nxt    = HOLD;
          hold_cnt_nxt = HOLD_LAST;
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_nxt     = RUN;
          load_done_nxt = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt - CW'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
    if (dn_download && state != LOAD) begin
      state_nxt     = LOAD;
      load_done_nxt = 1'b0;
      load_entry    = 1'b1;
    end
  end

`ifdef ROM_LOAD_CSUM_EN
  logic [15:0] csum_q = 16'h0000;

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      if (load_entry) begin
        csum_q <= 16'h0000;
      end else if (mem_we) begin
        csum_q <= csum_q + 16'(mem_din);
      end
    end
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter: vector table for write/read arbitration,
// hand sequences for reset, hold timing and download restart.
module tb_rom_load_arbiter;

  localparam int AW          = 15;
  localparam int ROM_SIZE    = 16384;
  localparam int HOLD_CYCLES = 1024;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dn_download;
  logic          dn_wr;
  logic [AW-1:0] dn_addr;
  logic [7:0]    dn_data;
  logic          dn_wait;
  logic          cpu_rd;
  logic [AW-1:0] cpu_addr;
  logic [7:0]    cpu_dout;
  logic          cpu_valid;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic [7:0]    mem_dout = 8'h00;
  logic          game_reset;
  logic          load_done;
`ifdef ROM_LOAD_CSUM_EN
  logic [15:0]   csum;
`endif

  int n_vec = 0;
  int n_err = 0;

  rom_load_arbiter #(.AW(AW), .ROM_SIZE(ROM_SIZE), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wait     (dn_wait),
    .cpu_rd      (cpu_rd),
    .cpu_addr    (cpu_addr),
    .cpu_dout    (cpu_dout),
    .cpu_valid   (cpu_valid),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_we      (mem_we),
    .mem_dout    (mem_dout),
    .game_reset  (game_reset),
    .load_done   (load_done)
`ifdef ROM_LOAD_CSUM_EN
    ,
    .csum        (csum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // Single-port synchronous RAM, read data one cycle after the address.
  logic [7:0] ram [0:32767];
  always @(posedge clk_sys) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end

  typedef struct {
    logic          wr;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          rd;
    logic [AW-1:0] raddr;
    logic          e_wait;
    logic          e_we;
    logic          chk_addr;
    logic [AW-1:0] e_addr;
    logic [7:0]    e_din;
    logic          e_valid;
    logic [7:0]    e_dout;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(logic wr, logic [AW-1:0] wa, logic [7:0] wd, logic rd,
                              logic [AW-1:0] ra, logic ew, logic ewe, logic ca,
                              logic [AW-1:0] ea, logic [7:0] ed, logic ev, logic [7:0] eo);
    vec_t v;
    v.wr = wr; v.waddr = wa; v.wdata = wd; v.rd = rd; v.raddr = ra;
    v.e_wait = ew; v.e_we = ewe; v.chk_addr = ca; v.e_addr = ea; v.e_din = ed;
    v.e_valid = ev; v.e_dout = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic apply_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cyc;
      dn_wr    = vecs[i].wr;
      dn_addr  = vecs[i].waddr;
      dn_data  = vecs[i].wdata;
      cpu_rd   = vecs[i].rd;
      cpu_addr = vecs[i].raddr;
      #1;
      chk($sformatf("v%0d_dn_wait", i), 32'(dn_wait), 32'(vecs[i].e_wait));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_cpu_valid", i), 32'(cpu_valid), 32'(vecs[i].e_valid));
      if (vecs[i].chk_addr) chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
      if (vecs[i].e_we) chk($sformatf("v%0d_mem_din", i), 32'(mem_din), 32'(vecs[i].e_din));
      if (vecs[i].e_valid) chk($sformatf("v%0d_cpu_dout", i), 32'(cpu_dout), 32'(vecs[i].e_dout));
    end
  endtask

  task automatic do_write(input string nm, input logic [AW-1:0] a, input logic [7:0] d);
    cyc;
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    #1;
    chk({nm, "_wait_lo"}, 32'(dn_wait), 32'd0);
    cyc;
    dn_wr = 1'b0;
    #1;
    chk({nm, "_wait_hi"}, 32'(dn_wait), 32'd1);
    chk({nm, "_we"}, 32'(mem_we), 32'd1);
    chk({nm, "_addr"}, 32'(mem_addr), 32'(a));
    chk({nm, "_din"}, 32'(mem_din), 32'(d));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad_gr, bad_ld, bad_we;
    for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
    ram[15'h0100] = 8'hA5;

    //        wr  waddr    wdata  rd raddr    wait we ca eaddr    edin   vld dout
    vecs[0]  = mk(1, 15'h0000, 8'h11, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[1]  = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 1, 1, 1, 15'h0000, 8'h11, 0, 8'h00);
    vecs[2]  = mk(1, 15'h0001, 8'h22, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[3]  = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 1, 1, 1, 15'h0001, 8'h22, 0, 8'h00);
    vecs[4]  = mk(1, 15'h0002, 8'h33, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[5]  = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 1, 1, 1, 15'h0002, 8'h33, 0, 8'h00);
    vecs[6]  = mk(1, 15'h0003, 8'h44, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[7]  = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 1, 1, 1, 15'h0003, 8'h44, 0, 8'h00);
    vecs[8]  = mk(1, 15'h4000, 8'h77, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[9]  = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 1, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[10] = mk(0, 15'h0000, 8'h00, 0, 15'h0000, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[11] = mk(1, 15'h0004, 8'h55, 1, 15'h0100, 0, 0, 1, 15'h0100, 8'h00, 0, 8'h00);
    vecs[12] = mk(0, 15'h0000, 8'h00, 1, 15'h0100, 1, 1, 1, 15'h0004, 8'h55, 1, 8'hA5);
    vecs[13] = mk(1, 15'h0005, 8'h66, 1, 15'h0100, 0, 0, 1, 15'h0100, 8'h00, 0, 8'h00);
    vecs[14] = mk(0, 15'h0000, 8'h00, 1, 15'h0100, 1, 1, 1, 15'h0005, 8'h66, 1, 8'hA5);
    vecs[15] = mk(0, 15'h0000, 8'h00, 0, 15'h0100, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[16] = mk(1, 15'h0006, 8'h01, 0, 15'h0100, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);
    vecs[17] = mk(1, 15'h0007, 8'h99, 1, 15'h0100, 1, 0, 1, 15'h0100, 8'h00, 0, 8'h00);
    vecs[18] = mk(1, 15'h0008, 8'h98, 0, 15'h0100, 1, 1, 1, 15'h0006, 8'h01, 1, 8'hA5);
    vecs[19] = mk(0, 15'h0000, 8'h00, 0, 15'h0100, 0, 0, 0, 15'h0000, 8'h00, 0, 8'h00);

    reset = 1'b1; dn_download = 1'b0; dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
    cpu_rd = 1'b1; cpu_addr = 15'h0100;

    // Outputs while reset is held, with a read request pending.
    cyc;
    chk("rst_dn_wait", 32'(dn_wait), 32'd0);
    chk("rst_cpu_valid", 32'(cpu_valid), 32'd0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_din", 32'(mem_din), 32'd0);
    chk("rst_game_reset", 32'(game_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    cyc;
    reset = 1'b0; cpu_rd = 1'b0;

    bad_gr = 0; bad_ld = 0; bad_we = 0;
    for (int i = 0; i < 5000; i++) begin
      cyc;
      if (game_reset !== 1'b1) bad_gr++;
      if (load_done !== 1'b0) bad_ld++;
      if (mem_we !== 1'b0) bad_we++;
    end
    chk("idle_game_reset_bad", 32'(bad_gr), 32'd0);
    chk("idle_load_done_bad", 32'(bad_ld), 32'd0);
    chk("idle_mem_we_bad", 32'(bad_we), 32'd0);

    cyc;
    dn_download = 1'b1;
    apply_range(0, 7);
`ifdef ROM_LOAD_CSUM_EN
    cyc;
    chk("csum_4bytes", 32'(csum), 32'h00AA);
`endif
    apply_range(8, 10);
`ifdef ROM_LOAD_CSUM_EN
    chk("csum_oob_unchanged", 32'(csum), 32'h00AA);
`endif
    apply_range(11, 19);
    chk("load_game_reset", 32'(game_reset), 32'd1);
    chk("load_load_done", 32'(load_done), 32'd0);

    // Hold timing counted from the edge that samples dn_download low.
    cyc;
    dn_download = 1'b0;
    cyc;
    chk("drain_game_reset", 32'(game_reset), 32'd1);
    n = 0;
    while (game_reset && n < 3000) begin
      cyc;
      n++;
    end
    chk("hold_len_after_load", 32'(n), 32'(HOLD_CYCLES + 1));
    chk("load_done_after_hold", 32'(load_done), 32'd1);
    chk("ram_byte3", 32'(ram[15'h0003]), 32'h44);
    chk("ram_oob_untouched", 32'(ram[15'h4000]), 32'h00);
    chk("ram_ignored_wr7", 32'(ram[15'h0007]), 32'h00);
    chk("ram_ignored_wr8", 32'(ram[15'h0008]), 32'h00);
`ifdef ROM_LOAD_CSUM_EN
    chk("csum_after_load", 32'(csum), 32'h0166);
`endif

    // Reset pulse while running: only the hold period replays.
    repeat (3) cyc;
    reset = 1'b1;
    #1;
    chk("runrst_game_reset", 32'(game_reset), 32'd1);
    chk("runrst_load_done", 32'(load_done), 32'd1);
    cyc;
    reset = 1'b0;
    #1;
    n = 0; bad_ld = 0;
    while (game_reset && n < 3000) begin
      if (load_done !== 1'b1) bad_ld++;
      cyc;
      n++;
    end
    chk("hold_len_after_reset", 32'(n), 32'(HOLD_CYCLES));
    chk("runrst_load_done_bad", 32'(bad_ld), 32'd0);
    chk("runrst_load_done_end", 32'(load_done), 32'd1);

    // Reset in the middle of a new download: buffered byte is lost, LOAD restarts.
    cyc;
    dn_download = 1'b1;
    do_write("rl_w1", 15'h0010, 8'hA1);
    chk("rl_load_done_cleared", 32'(load_done), 32'd0);
`ifdef ROM_LOAD_CSUM_EN
    cyc;
    chk("rl_csum_w1", 32'(csum), 32'h00A1);
`endif
    cyc;
    dn_wr = 1'b1; dn_addr = 15'h0011; dn_data = 8'hB2;
    #1;
    chk("rl_w2_wait_lo", 32'(dn_wait), 32'd0);
    cyc;
    dn_wr = 1'b0; reset = 1'b1;
    #1;
    chk("rl_rst_mem_we", 32'(mem_we), 32'd0);
    chk("rl_rst_dn_wait", 32'(dn_wait), 32'd0);
    cyc;
    reset = 1'b0;
    #1;
    chk("rl_boot_dn_wait", 32'(dn_wait), 32'd0);
    chk("rl_boot_load_done", 32'(load_done), 32'd0);
    chk("rl_boot_game_reset", 32'(game_reset), 32'd1);
    do_write("rl_w3", 15'h0012, 8'hC3);
`ifdef ROM_LOAD_CSUM_EN
    cyc;
    chk("rl_csum_w3", 32'(csum), 32'h00C3);
`endif

    // Last byte strobed as dn_download falls: DRAIN must flush it first.
    cyc;
    dn_wr = 1'b1; dn_addr = 15'h0013; dn_data = 8'hD4; dn_download = 1'b0;
    #1;
    chk("rl_w4_wait_lo", 32'(dn_wait), 32'd0);
    cyc;
    dn_wr = 1'b0;
    #1;
    chk("rl_w4_we", 32'(mem_we), 32'd1);
    chk("rl_w4_addr", 32'(mem_addr), 32'h0013);
    chk("rl_w4_din", 32'(mem_din), 32'hD4);
    n = 0;
    while (game_reset && n < 3000) begin
      cyc;
      n++;
    end
    chk("hold_len_full_drain", 32'(n), 32'(HOLD_CYCLES + 2));
    chk("rl_load_done_end", 32'(load_done), 32'd1);
    chk("rl_ram_lost_byte", 32'(ram[15'h0011]), 32'h00);
    chk("rl_ram_last_byte", 32'(ram[15'h0013]), 32'hD4);
`ifdef ROM_LOAD_CSUM_EN
    chk("rl_csum_end", 32'(csum), 32'h0197);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rom_load_arbiter.md
Name: rom_load_arbiter

Overview:
- Sits between the HPS ioctl download path and the game's program/graphics ROM RAM. This is a single-port synchronous RAM.
- Shares the RAM port between two requesters: byte writes from the HPS download, and the game CPU's reads.
- Back-pressures the host through the ioctl wait signal.
- Sequences the game reset: the game is held in reset until a complete image has been loaded and a settle period has elapsed.

Parameters:
- AW, 15, RAM address width in bits.
- ROM_SIZE, 16384, number of valid bytes. Writes at or above this address are dropped.
- HOLD_CYCLES, 1024, number of clk_sys cycles that game_reset stays asserted after the last write drains.

Ports:
- clk_sys  in  1  system clock; every register in the block uses it.
- reset  in  1  synchronous, active-high.
- dn_download  in  1  level; high while a ROM download is active (ioctl_download & index 0).
- dn_wr  in  1  one-cycle write strobe.
- dn_addr  in  AW  write byte address.
- dn_data  in  8  write byte.
- dn_wait  out  1  host must not strobe dn_wr while this is high.
- cpu_rd  in  1  read request; held high with cpu_addr stable until cpu_valid.
- cpu_addr  in  AW  read address.
- cpu_dout  out  8  read data; valid only when cpu_valid=1.
- cpu_valid  out  1  one-cycle pulse.
- mem_addr  out  AW  RAM address.
- mem_din  out  8  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_dout  in  8  RAM read data; appears 1 cycle after the address.
- game_reset  out  1  active-high reset to the game core.
- load_done  out  1  high once a full image has loaded and the hold period has expired.

Behaviour:
- Write buffer:
  - One entry: address, data and a full flag.
  - dn_wr with the buffer empty: capture the write, set full.
  - dn_wait = full.
  - dn_wr while full: ignored (protocol violation).
  - Accepted writes with dn_addr >= ROM_SIZE: captured, then discarded at grant. mem_we stays 0 for them.
- Arbitration, evaluated every cycle:
  - Candidates are the write buffer (if full) and cpu_rd (if high and no read is in flight).
  - Only one candidate: it wins.
  - Both: the one not granted last wins (round-robin; the last-grant flag resets to CPU).
  - Write grant: mem_we=1, mem_addr/mem_din come from the buffer, full clears the same cycle.
  - Read grant: mem_we=0, mem_addr=cpu_addr. The next cycle, cpu_valid=1 and cpu_dout=mem_dout (registered passthrough of RAM data).
  - Worst-case read latency is 2 cycles, which bounds CPU starvation. A new cpu_rd grant is possible in the cycle cpu_valid pulses.
- State machine, encoded BOOT/LOAD/DRAIN/HOLD/RUN:
  - BOOT: game_reset=1. Go to LOAD on dn_download=1.
  - LOAD: game_reset=1. load_done is cleared on entry. Go to DRAIN when dn_download=0.
  - DRAIN: game_reset=1. Go to HOLD once the buffer is empty. The hold counter is loaded with HOLD_CYCLES-1.
  - HOLD: game_reset=1. Counter decrements each cycle. At 0, go to RUN and set load_done=1.
  - RUN: game_reset=0.
  - dn_download=1 in any state other than LOAD: go to LOAD the next cycle.
- Reset:
  - State goes to HOLD (counter reloaded) if load_done=1, else to BOOT.
  - Buffer cleared, any in-flight read cancelled (no cpu_valid), last-grant set to CPU.
  - load_done is not altered by reset. Its configuration init value is 0.
  - Outputs during/after reset: dn_wait=0, cpu_valid=0, cpu_dout=0, mem_we=0, mem_addr=0, mem_din=0, game_reset=1.
- Simultaneous events:
  - dn_wr in the same cycle the buffer drains: not accepted (dn_wait was 1). The host retries.
  - dn_download falling with the buffer full: DRAIN completes the write before HOLD starts.
  - reset in LOAD mid-download: the buffer is lost. Since load_done=0, the next state is BOOT, and LOAD is re-entered if dn_download is still high.

Optional Feature:
- Macro: ROM_LOAD_CSUM_EN.
- With the macro: extra output port csum (16 bits).
  - csum is the modulo-65536 sum of every byte actually written to RAM (in-range writes only).
  - It is cleared on LOAD entry and frozen otherwise.
  - reset does not clear it.
- Without the macro: the port is absent and no adder is built.

Test Plan:
- Out of reset, dn_download=0 for 5000 cycles -> game_reset=1, load_done=0 throughout, mem_we never 1.
- Download 4 bytes 0x11,0x22,0x33,0x44 at addresses 0..3 with dn_wr one cycle apart, cpu_rd idle -> dn_wait is high for exactly 1 cycle after each strobe; mem_we pulses with the matching address/data; csum=0x00AA. After dn_download falls, game_reset deasserts exactly HOLD_CYCLES+1 cycles later (1 DRAIN cycle + HOLD_CYCLES) and load_done=1.
- Write to address 0x4000 (=ROM_SIZE) -> accepted (dn_wait pulses), mem_we stays 0, csum unchanged.
- cpu_rd held high continuously while the buffer refills every cycle possible -> grants alternate; cpu_valid at most 2 cycles after each request; data matches RAM preloaded with 0xA5 at cpu_addr 0x0100.
- In RUN, pulse reset -> state HOLD, game_reset=1 for HOLD_CYCLES cycles then 0, load_done stays 1 throughout.
- Assert reset after 2 of 4 download writes with dn_download still high -> BOOT for 1 cycle, then LOAD; load_done=0; the remaining writes complete normally.
